// File: rtl/mux4_scan_sequencer.sv
// Scan sequencer for a 4:1 bit mux. It steps the select lines through A..D and dwells
// on each channel, then samples the mux output and emits a 4-bit frame with a valid pulse.
module mux4_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode_cont,
  input  logic       abort,
  input  logic       mux_out,
  output logic       sel0,
  output logic       sel1,
  output logic [1:0] ch_idx,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ch_q, ch_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [3:0]       frame_q, frame_d;

  // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ch_d    = 2'd0;
          cnt_d   = RELOAD;
        end
      end
      SCAN: begin
        // abort outranks a sample that lands on the same edge
        if (abort) begin
          state_d = IDLE;
          ch_d    = 2'd0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ch_q != 2'd3) begin
          shadow_d[ch_q] = mux_out;
          ch_d           = ch_q + 2'd1;
          cnt_d          = RELOAD;
        end else begin
          frame_d = {mux_out, shadow_q};
          state_d = DONE;
          ch_d    = 2'd0;
        end
      end
      DONE: begin
        if (abort || !mode_cont) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
          cnt_d   = RELOAD;
          ch_d    = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. The small shadow register
  // is reset as well, so a scan that was cut short leaves no stale bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_q     <= 2'd0;
      shadow_q <= 3'b000;
      frame_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
    end
  end

  // The selects come straight from the registered channel index, so they move only on a step.
  assign sel0        = ch_q[1];
  assign sel1        = ch_q[0];
  assign ch_idx      = ch_q;
  assign busy        = (state_q != IDLE);
  assign frame       = frame_q;
  assign frame_valid = (state_q == DONE);

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Self-checking bench for mux4_scan_sequencer: two instances (DWELL=4 and DWELL=1) share stimulus
// and are scored against a timeline model of the scan (a channel k sample falls at (k+1)*DWELL edges after the start).
module tb_mux4_scan_sequencer;
  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode_cont = 1'b0;
  logic abort = 1'b0;
  logic [3:0] vals = 4'b0000;  // vals[k] = value presented on mux channel k

  logic       d0_sel0, d0_sel1, d0_busy, d0_fv, d0_mux;
  logic [1:0] d0_ch;
  logic [3:0] d0_frame;
  logic       d1_sel0, d1_sel1, d1_busy, d1_fv, d1_mux;
  logic [1:0] d1_ch;
  logic [3:0] d1_frame;

  assign d0_mux = vals[{d0_sel0, d0_sel1}];
  assign d1_mux = vals[{d1_sel0, d1_sel1}];

  mux4_scan_sequencer #(.DWELL(D0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont), .abort(abort),
    .mux_out(d0_mux), .sel0(d0_sel0), .sel1(d0_sel1), .ch_idx(d0_ch), .busy(d0_busy),
    .frame(d0_frame), .frame_valid(d0_fv)
  );

  mux4_scan_sequencer #(.DWELL(D1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont), .abort(abort),
    .mux_out(d1_mux), .sel0(d1_sel0), .sel1(d1_sel1), .ch_idx(d1_ch), .busy(d1_busy),
    .frame(d1_frame), .frame_valid(d1_fv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses0 = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a scan is an active flag, the edge it started on and the bits collected so far.
  int       dw[2] = '{D0, D1};
  int       e = 0;
  bit       m_act[2];
  bit       m_done[2];
  int       m_s[2];
  bit [3:0] m_bits[2];
  bit [3:0] m_frame[2];
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  task automatic model_step(input int i);
    int el, k;
    if (!m_act[i]) begin
      if (start) begin
        m_act[i] = 1'b1; m_done[i] = 1'b0; m_s[i] = e; m_bits[i] = 4'b0000;
      end
    end else if (m_done[i]) begin
      m_done[i] = 1'b0;
      if (abort || !mode_cont) m_act[i] = 1'b0;
      else begin m_s[i] = e; m_bits[i] = 4'b0000; end
    end else if (abort) begin
      m_act[i] = 1'b0;
    end else begin
      el = e - m_s[i];
      if (el % dw[i] == 0) begin
        k = el / dw[i] - 1;
        m_bits[i][k] = vals[k];
        if (k == 3) begin
          m_done[i]  = 1'b1;
          m_frame[i] = m_bits[i];
          if (i == 0) q0.push_back(m_bits[i]);
          else        q1.push_back(m_bits[i]);
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_done[i] = 1'b0; m_bits[i] = 4'b0000; m_frame[i] = 4'b0000;
      end
      q0.delete();
      q1.delete();
    end else begin
      e++;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Monitor: compares every output each cycle and pops the scoreboard on each frame_valid.
  task automatic mon(input int i, input logic s0, input logic s1, input logic [1:0] ch,
                     input logic b, input logic [3:0] fr, input logic fv);
    int exp_ch;
    logic [3:0] exp_fr;
    exp_ch = (m_act[i] && !m_done[i]) ? (e - m_s[i]) / dw[i] : 0;
    check($sformatf("d%0d_sel", i), 8'({s0, s1}), 8'(exp_ch));
    check($sformatf("d%0d_ch_idx", i), 8'(ch), 8'(exp_ch));
    check($sformatf("d%0d_busy", i), 8'(b), 8'(m_act[i]));
    check($sformatf("d%0d_frame_valid", i), 8'(fv), 8'(m_done[i]));
    check($sformatf("d%0d_frame", i), 8'(fr), 8'(m_frame[i]));
    if (fv) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        n_checks++;
        n_errors++;
        $display("FAIL d%0d_sb_frame: got %0h with no expected frame queued", i, fr);
      end else begin
        exp_fr = (i == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("d%0d_sb_frame", i), 8'(fr), 8'(exp_fr));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, d0_sel0, d0_sel1, d0_ch, d0_busy, d0_frame, d0_fv);
    mon(1, d1_sel0, d1_sel1, d1_ch, d1_busy, d1_frame, d1_fv);
    if (d0_fv) pulses0++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Single shot, A=1 B=0 C=1 D=1
    vals = 4'b1101;
    pulse_start();
    cyc(22);
    check("t1_frame", 8'(d0_frame), 8'h0d);
    check("t1_busy", 8'(d0_busy), 8'h00);

    // Continuous mode, dropped during the second scan
    vals = 4'b1110;
    mode_cont = 1'b1;
    pulses0 = 0;
    pulse_start();
    cyc(24);
    mode_cont = 1'b0;
    cyc(30);
    check("t2_pulses", 8'(pulses0), 8'd2);
    check("t2_frame", 8'(d0_frame), 8'h0e);

    // Abort at edge 9 after a completed 1101 frame
    vals = 4'b1101;
    pulse_start();
    cyc(22);
    pulse_start();
    cyc(8);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(3);
    check("t3_frame_kept", 8'(d0_frame), 8'h0d);
    check("t3_idle", 8'(d0_busy), 8'h00);
    vals = 4'b0110;
    pulse_start();
    cyc(22);
    check("t3_restart_frame", 8'(d0_frame), 8'h06);

    // start held high continuously
    vals = 4'b1011;
    start = 1'b1;
    cyc(45);
    start = 1'b0;
    cyc(20);

    // Asynchronous reset while dut0 dwells on channel C
    vals = 4'b1101;
    pulse_start();
    cyc(9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_sel", 8'({d0_sel0, d0_sel1}), 8'h00);
    check("t5_busy", 8'(d0_busy), 8'h00);
    check("t5_frame", 8'(d0_frame), 8'h00);
    check("t5_frame_valid", 8'(d0_fv), 8'h00);
    check("t5_d1_frame", 8'(d1_frame), 8'h00);
    #1 rst_n = 1'b1;
    cyc(3);

    // Only D set; dut1 (DWELL=1) finishes after 4 edges
    vals = 4'b1000;
    pulse_start();
    cyc(5);
    check("t6_d1_frame", 8'(d1_frame), 8'h08);
    cyc(18);
    check("t6_d0_frame", 8'(d0_frame), 8'h08);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      vals      = 4'($urandom);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      mode_cont = 1'($urandom);
      cyc(1);
    end
    start = 1'b0;
    abort = 1'b0;
    mode_cont = 1'b0;
    cyc(40);
    check("q0_drained", 8'(q0.size()), 8'd0);
    check("q1_drained", 8'(q1.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
